rri_histogram_streamer: RTL and testbench

- Builds a histogram of RR-interval samples in an internal bin memory, then streams it out bin by bin on request.
- Each output beat is a bin_index / distribution_value pair, in the form consumed by the downstream peak-search stage.
- Sits between RR-interval extraction (upstream) and the peak finder (downstream).
- Owns bin clearing, saturating accumulation and the sequential scan-out.

---
 rtl/rri_histogram_streamer.sv | 212 +++++++++++++++++++++
 tb/tb_rri_histogram_streamer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rri_histogram_streamer.sv
// ----------------------------------------------------------------------------
// rri_histogram_streamer
//
// Accumulates RR-interval samples into a histogram held in an internal
// synchronous-read bin memory, then streams the histogram out one bin per
// cycle as (bin_index, distribution_value) beats for the peak-search stage.
//
// Optional build macro: CLEAR_ON_SCAN_EN
//   defined   : a scan is read-and-clear; each bin is zeroed the cycle after
//               it is read, so a second scan with no new samples is all zero.
//   undefined : a scan is read-only; repeated scans return identical data.
//
// Ports
//   clk                 in   clock, rising edge
//   rst_n               in   asynchronous active-low reset
//   clear_start         in   1-cycle request: zero every bin
//   scan_start          in   1-cycle request: stream every bin
//   sample_valid        in   sample_value carries a sample
//   sample_value        in   RR interval in ms
//   sample_ready        out  sample taken when sample_valid && sample_ready
//   bin_index           out  bin of the current output beat
//   distribution_value  out  count held in bin_index
//   out_valid           out  beat valid this cycle (no backpressure)
//   scan_done           out  pulse with the beat for bin NUM_BINS-1
//   busy                out  high in every state except IDLE
//
// Flow
//   reset -> CLEAR (NUM_BINS cycles) -> IDLE
//   IDLE  -> CLEAR                 on clear_start  (highest priority)
//   IDLE  -> SCAN -> SCAN_END      on scan_start
//   IDLE  -> UPD_RD -> UPD_WR      on an accepted sample
// ----------------------------------------------------------------------------
module rri_histogram_streamer #(
    parameter int NUM_BINS  = 1024,
    parameter int IDX_W     = 10,
    parameter int CNT_W     = 32,
    parameter int SAMPLE_W  = 16,
    parameter int BIN_SHIFT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_start,
    input  logic                scan_start,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_value,
    output logic                sample_ready,
    output logic [IDX_W-1:0]    bin_index,
    output logic [CNT_W-1:0]    distribution_value,
    output logic                out_valid,
    output logic                scan_done,
    output logic                busy
);

    // Memory address width; the bin counter itself is IDX_W wide.
    localparam int AW = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
    localparam logic [IDX_W-1:0] LAST_BIN = IDX_W'(NUM_BINS - 1);

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_UPD_RD   = 3'd2,
        ST_UPD_WR   = 3'd3,
        ST_SCAN     = 3'd4,
        ST_SCAN_END = 3'd5
    } state_e;

    // Bin memory: written by one port, read synchronously into registers.
    logic [CNT_W-1:0] mem_q [NUM_BINS];

    state_e           state_q;
    logic [IDX_W-1:0] addr_q;        // shared clear / scan address
    logic [IDX_W-1:0] upd_addr_q;    // bin being incremented
    logic [CNT_W-1:0] upd_cnt_q;     // old count read in UPD_RD
    logic [IDX_W-1:0] bin_index_q;
    logic [CNT_W-1:0] dist_q;
    logic             out_valid_q;
    logic             scan_done_q;

    logic [31:0]      shifted;
    logic [IDX_W-1:0] bin_d;
    logic [CNT_W-1:0] inc_d;
    logic             idle;
    logic             accept;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [CNT_W-1:0] mem_wdata;

    // Bin selection: coarse quantisation by BIN_SHIFT; anything beyond the
    // last bin lands in the last bin so long intervals are still counted.
    always_comb begin
        shifted = 32'(sample_value) >> BIN_SHIFT;
        bin_d   = (shifted >= 32'(NUM_BINS)) ? LAST_BIN : shifted[IDX_W-1:0];
    end

    // Saturating increment: a full counter stays at all-ones.
    assign inc_d = (&upd_cnt_q) ? upd_cnt_q : upd_cnt_q + CNT_W'(1);

    assign idle = (state_q == ST_IDLE);
    // Ready is combinational on the commands so a winning command in the
    // same cycle blocks the handshake and the upstream keeps its sample.
    assign sample_ready = idle && !clear_start && !scan_start;
    assign accept       = sample_ready && sample_valid;
    assign busy         = !idle;

    assign bin_index          = bin_index_q;
    assign distribution_value = dist_q;
    assign out_valid          = out_valid_q;
    assign scan_done          = scan_done_q;

    // Write-port arbitration. The states that write never overlap, so a
    // simple priority chain is enough.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_q;
        mem_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                mem_we = 1'b1;
            end
            ST_UPD_WR: begin
                mem_we    = 1'b1;
                mem_waddr = upd_addr_q;
                mem_wdata = inc_d;
            end
            default: ;
        endcase
`ifdef CLEAR_ON_SCAN_EN
        // The beat on the output was read last cycle; zero that bin now.
        // This also covers the final bin during SCAN_END at no extra cost.
        if (out_valid_q) begin
            mem_we    = 1'b1;
            mem_waddr = bin_index_q;
            mem_wdata = '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr[AW-1:0]] <= mem_wdata;
        end
    end

    // Control FSM plus the registered read ports of the bin memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            addr_q      <= '0;
            upd_addr_q  <= '0;
            upd_cnt_q   <= '0;
            bin_index_q <= '0;
            dist_q      <= '0;
            out_valid_q <= 1'b0;
            scan_done_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            scan_done_q <= 1'b0;
            case (state_q)
                ST_CLEAR: begin
                    if (addr_q == LAST_BIN) begin
                        addr_q  <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        addr_q <= addr_q + IDX_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (clear_start) begin
                        addr_q  <= '0;
                        state_q <= ST_CLEAR;
                    end else if (scan_start) begin
                        addr_q  <= '0;
                        state_q <= ST_SCAN;
                    end else if (accept) begin
                        upd_addr_q <= bin_d;
                        state_q    <= ST_UPD_RD;
                    end
                end
                ST_UPD_RD: begin
                    upd_cnt_q <= mem_q[upd_addr_q[AW-1:0]];
                    state_q   <= ST_UPD_WR;
                end
                ST_UPD_WR: begin
                    state_q <= ST_IDLE;
                end
                ST_SCAN: begin
                    // The read lands directly in the output register, so the
                    // beat for address A appears the cycle after A is read.
                    dist_q      <= mem_q[addr_q[AW-1:0]];
                    bin_index_q <= addr_q;
                    out_valid_q <= 1'b1;
                    scan_done_q <= (addr_q == LAST_BIN);
                    if (addr_q == LAST_BIN) begin
                        addr_q  <= '0;
                        state_q <= ST_SCAN_END;
                    end else begin
                        addr_q <= addr_q + IDX_W'(1);
                    end
                end
                ST_SCAN_END: begin
                    // Cycle carrying the last beat; outputs drop next cycle.
                    state_q <= ST_IDLE;
                end
                default: begin
                    addr_q  <= '0;
                    state_q <= ST_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rri_histogram_streamer.sv
// ----------------------------------------------------------------------------
// Bench for rri_histogram_streamer. A reference histogram (plain array of
// counts, updated with clamp/saturate arithmetic) predicts every beat.
// A second, narrow instance (16 bins, 4-bit counters) exercises counter
// saturation in a handful of samples.
// ----------------------------------------------------------------------------
module tb_rri_histogram_streamer;

    localparam int NB   = 1024;
    localparam int SNB  = 16;
    localparam longint unsigned CMAX = 64'hFFFF_FFFF;
    localparam longint unsigned SMAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b1;
    logic        clear_start = 1'b0, scan_start = 1'b0, sample_valid = 1'b0;
    logic [15:0] sample_value = '0;
    logic        sample_ready, out_valid, scan_done, busy;
    logic [9:0]  bin_index;
    logic [31:0] distribution_value;

    logic        s_clear = 1'b0, s_scan = 1'b0, s_valid = 1'b0;
    logic [15:0] s_value = '0;
    logic        s_ready, s_out_valid, s_done, s_busy;
    logic [3:0]  s_bin;
    logic [3:0]  s_dist;

    rri_histogram_streamer dut (
        .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .scan_start(scan_start),
        .sample_valid(sample_valid), .sample_value(sample_value), .sample_ready(sample_ready),
        .bin_index(bin_index), .distribution_value(distribution_value),
        .out_valid(out_valid), .scan_done(scan_done), .busy(busy)
    );

    rri_histogram_streamer #(.NUM_BINS(SNB), .IDX_W(4), .CNT_W(4), .SAMPLE_W(16), .BIN_SHIFT(2)) u_small (
        .clk(clk), .rst_n(rst_n), .clear_start(s_clear), .scan_start(s_scan),
        .sample_valid(s_valid), .sample_value(s_value), .sample_ready(s_ready),
        .bin_index(s_bin), .distribution_value(s_dist),
        .out_valid(s_out_valid), .scan_done(s_done), .busy(s_busy)
    );

    int checks = 0;
    int failures = 0;
    longint unsigned model [NB];
    longint unsigned smodel[SNB];
    longint unsigned got   [NB];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_add(input int unsigned v);
        int unsigned b;
        b = v / 4;
        if (b >= NB) b = NB - 1;
        if (model[b] < CMAX) model[b] = model[b] + 1;
    endfunction

    function automatic void model_zero();
        foreach (model[i]) model[i] = 0;
    endfunction

    // Counts rising edges until busy drops; the caller sits just after the
    // edge that entered CLEAR.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_clear_cycles"}, n, NB);
        check({tag, "_ready_after_clear"}, sample_ready, 1'b1);
    endtask

    task automatic send_samples(input string tag, input int unsigned vals[$], input bit cont);
        int idx, last, bad_gap;
        idx = 0; last = -1; bad_gap = 0;
        for (int cyc = 0; cyc < 1000 && idx < vals.size(); cyc++) begin
            @(negedge clk);
            sample_valid = cont ? 1'b1 : ($urandom_range(0, 2) != 0);
            sample_value = 16'(vals[idx]);
            #1;
            if (sample_valid && sample_ready) begin
                if (cont && last >= 0 && (cyc - last) != 3) bad_gap++;
                last = cyc;
                model_add(vals[idx]);
                idx++;
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        check({tag, "_accepted"}, idx, vals.size());
        if (cont) check({tag, "_spacing_errors"}, bad_gap, 0);
    endtask

    // Pulses scan_start and checks every beat against the model.
    // abort_at > 0 pulls reset after that many beats; mid_cmd fires both
    // commands in the middle of the scan, which must be ignored.
    task automatic run_scan(input string tag, input int abort_at, input bit mid_cmd);
        int beats, bad_idx, bad_val, bad_done, first_at, gap;
        longint unsigned last_exp;
        beats = 0; bad_idx = 0; bad_val = 0; bad_done = 0; first_at = -1; gap = 0;
        last_exp = model[NB-1];
        @(negedge clk); scan_start = 1'b1;
        @(negedge clk); scan_start = 1'b0;
        for (int cyc = 0; cyc < NB + 10 && beats < NB; cyc++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                if (first_at < 0) first_at = cyc;
                if (bin_index !== 10'(beats)) bad_idx++;
                if (distribution_value !== 32'(model[beats])) bad_val++;
                if (scan_done !== (beats == NB - 1)) bad_done++;
                got[beats] = distribution_value;
                beats++;
                if (abort_at > 0 && beats == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check({tag, "_abort_out_valid"}, out_valid, 1'b0);
                    check({tag, "_abort_busy"}, busy, 1'b1);
                    check({tag, "_abort_bin_index"}, bin_index, 0);
                    check({tag, "_abort_vals_ok"}, bad_val, 0);
                    return;
                end
            end else begin
                if (first_at >= 0) gap++;
                if (scan_done !== 1'b0) bad_done++;
            end
            scan_start  = mid_cmd && (beats == 500);
            clear_start = mid_cmd && (beats == 500);
        end
        scan_start = 1'b0; clear_start = 1'b0;
        check({tag, "_beats"}, beats, NB);
        check({tag, "_first_beat_latency"}, first_at, 0);
        check({tag, "_gaps"}, gap, 0);
        check({tag, "_index_errors"}, bad_idx, 0);
        check({tag, "_value_errors"}, bad_val, 0);
        check({tag, "_done_errors"}, bad_done, 0);
        @(posedge clk); #1;
        check({tag, "_post_out_valid"}, out_valid, 1'b0);
        check({tag, "_post_scan_done"}, scan_done, 1'b0);
        check({tag, "_post_idle"}, busy, 1'b0);
        check({tag, "_hold_index"}, bin_index, NB - 1);
        check({tag, "_hold_value"}, distribution_value, last_exp);
`ifdef CLEAR_ON_SCAN_EN
        model_zero();
`endif
    endtask

    initial begin
        int unsigned vals[$];
        int si, sb, sbad;
        logic [3:0] sat_seen;

        model_zero();
        foreach (smodel[i]) smodel[i] = 0;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_bin_index", bin_index, 0);
        check("rst_dist", distribution_value, 0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_scan_done", scan_done, 1'b0);
        check("rst_sample_ready", sample_ready, 1'b0);
        check("rst_busy", busy, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_clear("por");

        // Fresh histogram is all zero
        run_scan("scan_zero", 0, 1'b0);

        // Saturation on the narrow instance: 17 hits on bin 5 cap at 15,
        // one oversize sample clamps into the last bin.
        si = 0;
        for (int cyc = 0; cyc < 200 && si < 18; cyc++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_value = (si == 17) ? 16'd1000 : 16'd20;
            #1;
            if (s_ready) begin
                if (si == 17) begin
                    if (smodel[SNB-1] < SMAX) smodel[SNB-1]++;
                end else if (smodel[5] < SMAX) smodel[5]++;
                si++;
            end
        end
        @(negedge clk); s_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_accepted", si, 18);
        s_scan = 1'b1;
        @(negedge clk); s_scan = 1'b0;
        sb = 0; sbad = 0; sat_seen = '0;
        for (int cyc = 0; cyc < 40 && sb < SNB; cyc++) begin
            @(posedge clk); #1;
            if (s_out_valid === 1'b1) begin
                if (s_bin !== 4'(sb)) sbad++;
                if (s_dist !== 4'(smodel[sb])) sbad++;
                if (sb == 5) sat_seen = s_dist;
                sb++;
            end
        end
        check("sat_beats", sb, SNB);
        check("sat_errors", sbad, 0);
        check("sat_bin5", sat_seen, 4'hF);

        // Directed samples including clamp
        vals = '{800, 801, 803, 4000, 5000};
        send_samples("dir", vals, 1'b1);
        run_scan("scan_dir", 0, 1'b0);
        check("dir_bin200", got[200], 3);
        check("dir_bin1000", got[1000], 1);
        check("dir_bin1023", got[1023], 1);

        // Six samples with valid held high, then two back-to-back scans
        vals.delete();
        for (int i = 0; i < 6; i++) vals.push_back($urandom_range(0, 4400));
        send_samples("cont6", vals, 1'b1);
        run_scan("scan_a", 0, 1'b0);
        run_scan("scan_b", 0, 1'b0);

        // clear_start and scan_start together with a sample waiting
        send_samples("pre_clr", '{100, 200, 300}, 1'b1);
        @(negedge clk);
        clear_start = 1'b1; scan_start = 1'b1; sample_valid = 1'b1; sample_value = 16'd40;
        #1;
        check("cmd_blocks_ready", sample_ready, 1'b0);
        @(negedge clk);
        clear_start = 1'b0; scan_start = 1'b0; sample_valid = 1'b0;
        model_zero();
        wait_clear("clr_cmd");
        run_scan("after_clr", 0, 1'b0);

        // Random samples with random valid gaps, scan with stray commands
        vals.delete();
        for (int i = 0; i < 24; i++) vals.push_back($urandom_range(0, 6000));
        send_samples("rand", vals, 1'b0);
        run_scan("scan_rand", 0, 1'b1);

        // Reset in the middle of a scan
        send_samples("pre_abort", '{1200, 1204, 64}, 1'b1);
        run_scan("abort", 300, 1'b0);
        model_zero();
        @(negedge clk);
        rst_n = 1'b1;
        wait_clear("rst_mid");
        run_scan("after_abort", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Backstop so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
